// File: rtl/gps_sentence_ctrl.sv
// NMEA sentence framer: checks '$'..'*hh'<CR> framing and checksum, streams
// field bytes to a field buffer, and tracks the GPRMC fix status.
module gps_sentence_ctrl #(
    parameter int MAX_LEN      = 82,
    parameter int BYTE_TIMEOUT = 5_000_000
) (
    input  logic       clock_50mhz,
    input  logic       reset,
    input  logic       data_valid,
    input  logic [7:0] data,
    output logic       wr_en,
    output logic [7:0] wr_data,
    output logic [3:0] field_idx,
    output logic [3:0] char_idx,
    output logic       commit,
    output logic       sentence_err,
    output logic       rmc_fix,
    output logic       busy
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_BODY     = 3'd1;
    localparam logic [2:0] S_CK_HI    = 3'd2;
    localparam logic [2:0] S_CK_LO    = 3'd3;
    localparam logic [2:0] S_WAIT_EOL = 3'd4;

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(BYTE_TIMEOUT + 1);

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_A      = 8'h41;

    logic [2:0]    state;
    logic [7:0]    csum;
    logic [7:0]    rx_ck;
    logic [3:0]    cidx;
    logic [LW-1:0] len_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          hdr_ok;
    logic [7:0]    status;
    logic          hex_ok;
    logic [3:0]    hex_val;
    logic          hdr_final;

    function automatic logic [7:0] hdr_char(input logic [3:0] i);
        case (i)
            4'd0:    hdr_char = 8'h47; // G
            4'd1:    hdr_char = 8'h50; // P
            4'd2:    hdr_char = 8'h52; // R
            4'd3:    hdr_char = 8'h4D; // M
            4'd4:    hdr_char = 8'h43; // C
            default: hdr_char = 8'h00;
        endcase
    endfunction

    always_comb begin
        hex_ok  = 1'b0;
        hex_val = 4'd0;
        if (data >= 8'h30 && data <= 8'h39) begin
            hex_ok  = 1'b1;
            hex_val = data[3:0];
        end else if (data >= 8'h41 && data <= 8'h46) begin
            hex_ok  = 1'b1;
            hex_val = data[3:0] + 4'd9;
        end
    end

    // A sentence with no comma still matches if field 0 is exactly "GPRMC".
    assign hdr_final = hdr_ok && (field_idx != 4'd0 || cidx == 4'd5);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clock_50mhz) begin
        if (reset) begin
            state        <= S_IDLE;
            csum         <= 8'd0;
            rx_ck        <= 8'd0;
            cidx         <= 4'd0;
            len_cnt      <= '0;
            tmo_cnt      <= '0;
            hdr_ok       <= 1'b0;
            status       <= 8'd0;
            wr_en        <= 1'b0;
            wr_data      <= 8'd0;
            field_idx    <= 4'd0;
            char_idx     <= 4'd0;
            commit       <= 1'b0;
            sentence_err <= 1'b0;
            rmc_fix      <= 1'b0;
        end else begin
            wr_en        <= 1'b0;
            commit       <= 1'b0;
            sentence_err <= 1'b0;
            if (data_valid) begin
                tmo_cnt <= '0;
                if (data == CH_DOLLAR) begin
                    if (state != S_IDLE) sentence_err <= 1'b1;
                    state     <= S_BODY;
                    csum      <= 8'd0;
                    field_idx <= 4'd0;
                    cidx      <= 4'd0;
                    char_idx  <= 4'd0;
                    len_cnt   <= LW'(1);
                    hdr_ok    <= 1'b1;
                    status    <= 8'd0;
                end else if (state != S_IDLE) begin
                    if (len_cnt == LW'(MAX_LEN)) begin
                        sentence_err <= 1'b1;
                        state        <= S_IDLE;
                    end else begin
                        len_cnt <= len_cnt + LW'(1);
                        case (state)
                            S_BODY: begin
                                if (data == CH_STAR) begin
                                    state <= S_CK_HI;
                                end else begin
                                    csum <= csum ^ data;
                                    if (data == CH_COMMA) begin
                                        if (field_idx != 4'd15) field_idx <= field_idx + 4'd1;
                                        cidx     <= 4'd0;
                                        char_idx <= 4'd0;
                                        if (field_idx == 4'd0 && cidx != 4'd5) hdr_ok <= 1'b0;
                                    end else begin
                                        // char_idx shows the pre-increment position alongside wr_en
                                        wr_en    <= 1'b1;
                                        wr_data  <= data;
                                        char_idx <= cidx;
                                        if (cidx != 4'd15) cidx <= cidx + 4'd1;
                                        if (field_idx == 4'd0 && (cidx >= 4'd5 || data != hdr_char(cidx)))
                                            hdr_ok <= 1'b0;
                                        if (field_idx == 4'd2 && cidx == 4'd0) status <= data;
                                    end
                                end
                            end
                            S_CK_HI: begin
                                if (hex_ok) begin
                                    rx_ck[7:4] <= hex_val;
                                    state      <= S_CK_LO;
                                end else begin
                                    sentence_err <= 1'b1;
                                    state        <= S_IDLE;
                                end
                            end
                            S_CK_LO: begin
                                if (hex_ok) begin
                                    rx_ck[3:0] <= hex_val;
                                    state      <= S_WAIT_EOL;
                                end else begin
                                    sentence_err <= 1'b1;
                                    state        <= S_IDLE;
                                end
                            end
                            S_WAIT_EOL: begin
                                state <= S_IDLE;
                                if (data == CH_CR && rx_ck == csum) begin
                                    commit <= 1'b1;
                                    if (hdr_final) rmc_fix <= (status == CH_A);
                                end else begin
                                    sentence_err <= 1'b1;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            end else if (state != S_IDLE) begin
                if (tmo_cnt == TW'(BYTE_TIMEOUT - 1)) begin
                    sentence_err <= 1'b1;
                    state        <= S_IDLE;
                    tmo_cnt      <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_gps_sentence_ctrl.sv
// Directed bench for gps_sentence_ctrl: framing, checksum, GPRMC fix, restart,
// length limit, timeout and reset behaviour.
module tb_gps_sentence_ctrl;
    logic       clock_50mhz = 1'b0;
    logic       reset = 1'b1;
    logic       data_valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic       wr_en, commit, sentence_err, rmc_fix, busy;
    logic [7:0] wr_data;
    logic [3:0] field_idx, char_idx;

    int tests = 0;
    int fails = 0;

    gps_sentence_ctrl #(.MAX_LEN(82), .BYTE_TIMEOUT(100)) dut (
        .clock_50mhz(clock_50mhz), .reset(reset), .data_valid(data_valid), .data(data),
        .wr_en(wr_en), .wr_data(wr_data), .field_idx(field_idx), .char_idx(char_idx),
        .commit(commit), .sentence_err(sentence_err), .rmc_fix(rmc_fix), .busy(busy)
    );

    always #10 clock_50mhz = ~clock_50mhz;

    logic [15:0] wq[$];
    int          n_commit = 0;
    int          n_err = 0;
    int          n_both = 0;
    logic        fix_at_commit = 1'b0;

    always @(negedge clock_50mhz) begin
        if (wr_en) wq.push_back({field_idx, char_idx, wr_data});
        if (commit) begin
            n_commit++;
            fix_at_commit = rmc_fix;
        end
        if (sentence_err) n_err++;
        if (commit && sentence_err) n_both++;
    end

    task automatic send(input logic [7:0] b);
        @(negedge clock_50mhz);
        data_valid = 1'b1;
        data = b;
        @(negedge clock_50mhz);
        data_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic settle;
        repeat (3) @(negedge clock_50mhz);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clock_50mhz);
        #1;
        tests++;
        if ({wr_en, wr_data, field_idx, char_idx, commit, sentence_err, rmc_fix, busy} !== 23'd0) begin
            $display("FAIL reset_state: got %b want all zero",
                     {wr_en, wr_data, field_idx, char_idx, commit, sentence_err, rmc_fix, busy});
            fails++;
        end
        @(negedge clock_50mhz);
        reset = 1'b0;
    endtask

    task automatic test_gprmc_fix;
        logic [15:0] exp_w [6];
        int c0, e0;
        exp_w = '{16'h0047, 16'h0150, 16'h0252, 16'h034D, 16'h0443, 16'h2041};
        c0 = n_commit; e0 = n_err; wq.delete();
        send(8'h0A);
        send_str("$GPRMC,,A*0A");
        send(8'h0D);
        settle();
        tests++;
        if (wq.size() != 6) begin
            $display("FAIL gprmc_wr_count: got %0d want 6", wq.size()); fails++;
        end else begin
            for (int i = 0; i < 6; i++) begin
                tests++;
                if (wq[i] !== exp_w[i]) begin
                    $display("FAIL gprmc_wr[%0d]: got %h want %h", i, wq[i], exp_w[i]); fails++;
                end
            end
        end
        tests++;
        if (n_commit - c0 != 1 || n_err - e0 != 0) begin
            $display("FAIL gprmc_commit: commits %0d errs %0d want 1 0", n_commit - c0, n_err - e0); fails++;
        end
        tests++;
        if (rmc_fix !== 1'b1 || fix_at_commit !== 1'b1) begin
            $display("FAIL gprmc_fix: got %b (at commit %b) want 1", rmc_fix, fix_at_commit); fails++;
        end
    endtask

    task automatic test_other_type;
        int c0, e0;
        c0 = n_commit; e0 = n_err;
        send_str("$AB*03"); send(8'h0D); settle();
        tests++;
        if (n_commit - c0 != 1 || n_err - e0 != 0 || rmc_fix !== 1'b1) begin
            $display("FAIL other_commit: commits %0d errs %0d fix %b want 1 0 1", n_commit - c0, n_err - e0, rmc_fix);
            fails++;
        end
        c0 = n_commit; e0 = n_err;
        send_str("$AB*04"); send(8'h0D); settle();
        tests++;
        if (n_commit - c0 != 0 || n_err - e0 != 1) begin
            $display("FAIL bad_checksum: commits %0d errs %0d want 0 1", n_commit - c0, n_err - e0); fails++;
        end
    endtask

    task automatic test_gprmc_nofix;
        int c0;
        c0 = n_commit;
        send_str("$GPRMC,,V*1D"); send(8'h0D); settle();
        tests++;
        if (n_commit - c0 != 1 || rmc_fix !== 1'b0) begin
            $display("FAIL gprmc_nofix: commits %0d fix %b want 1 0", n_commit - c0, rmc_fix); fails++;
        end
    endtask

    task automatic test_restart;
        int c0, e0;
        c0 = n_commit; e0 = n_err;
        send_str("$AB$AB*03"); send(8'h0D); settle();
        tests++;
        if (n_commit - c0 != 1 || n_err - e0 != 1) begin
            $display("FAIL restart: commits %0d errs %0d want 1 1", n_commit - c0, n_err - e0); fails++;
        end
    endtask

    task automatic test_lowercase;
        int c0, e0;
        c0 = n_commit; e0 = n_err;
        send_str("$AB*0a"); send(8'h0D); settle();
        tests++;
        if (n_commit - c0 != 0 || n_err - e0 != 1) begin
            $display("FAIL lowercase_hex: commits %0d errs %0d want 0 1", n_commit - c0, n_err - e0); fails++;
        end
    endtask

    // 77 body bytes -> 82 total (commit); 78 body bytes -> CR is byte 83 (error)
    task automatic test_max_len;
        int c0, e0;
        c0 = n_commit; e0 = n_err;
        send("$");
        for (int i = 0; i < 77; i++) send(8'h41);
        send_str("*41"); send(8'h0D); settle();
        tests++;
        if (n_commit - c0 != 1 || n_err - e0 != 0) begin
            $display("FAIL len_at_max: commits %0d errs %0d want 1 0", n_commit - c0, n_err - e0); fails++;
        end
        c0 = n_commit; e0 = n_err;
        send("$");
        for (int i = 0; i < 78; i++) send(8'h41);
        send_str("*00"); send(8'h0D); settle();
        tests++;
        if (n_commit - c0 != 0 || n_err - e0 != 1) begin
            $display("FAIL len_over_max: commits %0d errs %0d want 0 1", n_commit - c0, n_err - e0); fails++;
        end
    endtask

    task automatic test_back_to_back;
        string s;
        int c0;
        s = "$AB*03";
        c0 = n_commit; wq.delete();
        for (int i = 0; i <= s.len(); i++) begin
            @(negedge clock_50mhz);
            data_valid = 1'b1;
            data = (i == s.len()) ? 8'h0D : s[i];
        end
        @(negedge clock_50mhz);
        data_valid = 1'b0;
        settle();
        tests++;
        if (wq.size() != 2 || wq[0] !== 16'h0041 || wq[1] !== 16'h0142) begin
            $display("FAIL b2b_writes: got %0d entries first %h want 2 entries 0041 0142",
                     wq.size(), (wq.size() > 0) ? wq[0] : 16'hxxxx);
            fails++;
        end
        tests++;
        if (n_commit - c0 != 1) begin
            $display("FAIL b2b_commit: got %0d want 1", n_commit - c0); fails++;
        end
    endtask

    task automatic test_reset_mid;
        int c0, e0;
        send_str("$GPRMC,,A*0A"); send(8'h0D); settle();
        tests++;
        if (rmc_fix !== 1'b1) begin
            $display("FAIL pre_reset_fix: got %b want 1", rmc_fix); fails++;
        end
        c0 = n_commit; e0 = n_err;
        send_str("$GPR");
        @(negedge clock_50mhz);
        reset = 1'b1;
        @(posedge clock_50mhz);
        #1;
        tests++;
        if ({wr_en, wr_data, field_idx, char_idx, commit, sentence_err, rmc_fix, busy} !== 23'd0) begin
            $display("FAIL reset_mid_outputs: got %b want all zero",
                     {wr_en, wr_data, field_idx, char_idx, commit, sentence_err, rmc_fix, busy});
            fails++;
        end
        @(negedge clock_50mhz);
        reset = 1'b0;
        data_valid = 1'b1;
        data = "$";
        @(negedge clock_50mhz);
        data_valid = 1'b0;
        tests++;
        if (n_commit - c0 != 0 || n_err - e0 != 0) begin
            $display("FAIL reset_mid_pulses: commits %0d errs %0d want 0 0", n_commit - c0, n_err - e0); fails++;
        end
        send_str("AB*03"); send(8'h0D); settle();
        tests++;
        if (n_commit - c0 != 1 || n_err - e0 != 0) begin
            $display("FAIL post_reset_commit: commits %0d errs %0d want 1 0", n_commit - c0, n_err - e0); fails++;
        end
    endtask

    task automatic test_timeout;
        int got;
        got = -1;
        send_str("$AB");
        for (int k = 1; k <= 200; k++) begin
            @(posedge clock_50mhz);
            #1;
            if (sentence_err) begin
                got = k;
                break;
            end
        end
        tests++;
        if (got != 100) begin
            $display("FAIL timeout_latency: got %0d want 100", got); fails++;
        end
        tests++;
        if (busy !== 1'b0) begin
            $display("FAIL timeout_busy: got %b want 0", busy); fails++;
        end
    endtask

    initial begin
        test_reset();
        test_gprmc_fix();
        test_other_type();
        test_gprmc_nofix();
        test_restart();
        test_lowercase();
        test_max_len();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        settle();
        tests++;
        if (n_both != 0) begin
            $display("FAIL commit_err_overlap: got %0d want 0", n_both); fails++;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gps_sentence_ctrl.md
GPS_SENTENCE_CTRL -- requirements
Module: gps_sentence_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 82: maximum sentence length in bytes, '$' through CR inclusive.
REQ-002 SHALL have parameter BYTE_TIMEOUT, default 5_000_000: maximum clocks allowed between accepted bytes inside a sentence (100 ms at 50 MHz).
REQ-003 SHALL have port clock_50mhz, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port data_valid, input, 1 bit: one-cycle strobe, already synchronous to clock_50mhz, qualifying data.
REQ-006 SHALL have port data, input, 8 bits: received ASCII byte.
REQ-007 SHALL have port wr_en, output, 1 bit: one-cycle pulse; store wr_data into the field buffer.
REQ-008 SHALL have port wr_data, output, 8 bits: byte to store.
REQ-009 SHALL have port field_idx, output, 4 bits: comma count within the sentence, saturating at 15.
REQ-010 SHALL have port char_idx, output, 4 bits: character position within the current field, saturating at 15.
REQ-011 SHALL have port commit, output, 1 bit: one-cycle pulse; the sentence just ended passed all checks.
REQ-012 SHALL have port sentence_err, output, 1 bit: one-cycle pulse; the sentence was aborted or failed checks.
REQ-013 SHALL have port rmc_fix, output, 1 bit: level; the last committed GPRMC sentence had status 'A'.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL implement the states IDLE, BODY, CK_HI, CK_LO and WAIT_EOL, and SHALL act only on cycles where data_valid=1, except for the timeout.
REQ-016 IDLE SHALL discard every byte except '$' (0x24); '$' SHALL clear the checksum, field_idx, char_idx, the length count, the header match and the status capture, then enter BODY.
REQ-017 In BODY, each byte other than '*' SHALL be XORed into the 8-bit running checksum.
REQ-018 In BODY, ',' SHALL increment field_idx (saturating) and clear char_idx, and SHALL NOT pulse wr_en.
REQ-019 In BODY, any other byte except '*' and '$' SHALL pulse wr_en in the next cycle (latency 1), with wr_data, field_idx and char_idx valid in that same cycle; char_idx then increments, saturating.
REQ-020 The header SHALL match "GPRMC" when field 0 characters 0..4 equal those bytes and field 0 is exactly 5 characters long.
REQ-021 The status capture SHALL be the first byte of field 2.
REQ-022 '*' in BODY SHALL go to CK_HI.
REQ-023 CK_HI and CK_LO SHALL each accept one uppercase hex digit (0-9, A-F), forming the received checksum from high nibble then low nibble; any other byte SHALL be an error.
REQ-024 After CK_LO, the state SHALL be WAIT_EOL; in WAIT_EOL, CR (0x0D) SHALL end the sentence and any other byte SHALL be an error.
REQ-025 At sentence end, if the received checksum equals the computed checksum, commit SHALL pulse in the next cycle; otherwise sentence_err SHALL pulse in the next cycle. The state SHALL return to IDLE in either case.
REQ-026 On commit with a GPRMC header match, rmc_fix SHALL update to (status capture == 'A') in the same cycle as commit; commit of any other sentence type SHALL leave rmc_fix unchanged.
REQ-027 On any error, the block SHALL pulse sentence_err once, go to IDLE and SHALL NOT pulse commit.
REQ-028 '$' in any non-IDLE state SHALL pulse sentence_err and restart the sentence as in REQ-016, without passing through IDLE.
REQ-029 A byte that would make the length count exceed MAX_LEN SHALL be an error.
REQ-030 When busy and BYTE_TIMEOUT clocks elapse with no data_valid, the block SHALL pulse sentence_err and go to IDLE; the timeout counter SHALL reset on every accepted byte.
REQ-031 LF (0x0A) SHALL be ignored in IDLE.
REQ-032 commit and sentence_err SHALL never be high in the same cycle, and each sentence SHALL produce at most one of them.

Reset
REQ-033 Reset SHALL force IDLE, and SHALL clear wr_en, wr_data, field_idx, char_idx, commit, sentence_err, rmc_fix, busy, the checksum and the counters, all in the next cycle.
REQ-034 Reset SHALL take priority over data_valid.
REQ-035 Reset mid-sentence SHALL emit neither commit nor sentence_err.
REQ-036 After reset, the block SHALL accept a '$' on the first cycle after reset deasserts.

Verification
REQ-037 Bytes "$GPRMC,,A*0A" then CR -> 6 wr_en pulses (field 0 chars 0-4, field 2 char 0 = 'A'), then commit pulse, rmc_fix=1.
REQ-038 Bytes "$AB*03" then CR -> commit pulse, rmc_fix unchanged; "$AB*04" then CR -> sentence_err pulse, no commit.
REQ-039 Bytes "$GPRMC,,V*1D" then CR after a prior 'A' fix -> commit pulse, rmc_fix falls to 0.
REQ-040 Bytes "$AB" then "$AB*03" then CR -> exactly one sentence_err pulse at the second '$', then one commit pulse.
REQ-041 With BYTE_TIMEOUT=100, bytes "$AB" followed by silence -> sentence_err pulse 100 clocks after 'B', busy=0; a lowercase "*0a" checksum -> sentence_err pulse.
REQ-042 Reset asserted after "$GPR" -> all outputs 0 the next cycle, no commit or sentence_err; a following "$AB*03" then CR -> commit pulse.
